// File: rtl/packet_stream_arbiter_pkg.sv
// Shared types and default sizing for the packet stream arbiter.
// The default constants are used by the interface and the top level.
package pkt_arb_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_USER_W = 8;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    STREAM
  } arb_state_t;

endpackage

// File: rtl/packet_stream_arbiter_if.sv
// Bundles the N_CH-wide upstream AXI-Stream side and the single downstream side.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface packet_stream_arbiter_if
  import pkt_arb_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int USER_W = DEF_USER_W
);

  logic [N_CH*DATA_W-1:0] s_tdata;
  logic [N_CH-1:0]        s_tvalid;
  logic [N_CH-1:0]        s_tready;
  logic [DATA_W-1:0]      m_tdata;
  logic [USER_W-1:0]      m_tuser;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tuser, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tvalid, m_tlast
  );

endinterface

// File: rtl/packet_stream_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted req searching ptr+1, ptr+2, ... mod N_CH.
// The channel at ptr itself has the lowest priority.
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [$clog2(N_CH)-1:0] gnt_idx,
  output logic                    gnt_any
);

  localparam int CH_W = $clog2(N_CH);

  logic [CH_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest requester wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    gnt_idx = '0;
    cand    = '0;
    gnt_any = |req;
    for (int i = N_CH; i >= 1; i--) begin
      cand = CH_W'((int'(ptr) + i) % N_CH);
      if (req[cand]) gnt_idx = cand;
    end
  end

endmodule

// File: rtl/packet_stream_arbiter.sv
// Grants one upstream channel at a time for a whole packet of (pkt_len+1) beats,
// round-robin between packets, with zero-latency passthrough while streaming.
module packet_stream_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int USER_W = DEF_USER_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [LEN_W-1:0]          pkt_len,
  packet_stream_arbiter_if.slave    bus,
  output logic [$clog2(N_CH)-1:0]   grant_ch,
  output logic                      busy,
  output logic                      pkt_done
);

  localparam int CH_W = $clog2(N_CH);

  arb_state_t      state;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_q;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  arb_idx;
  logic             arb_any;
  logic             streaming;
  logic             cur_valid;
  logic             last_beat;
  logic             xfer;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req     (bus.s_tvalid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign streaming = (state == STREAM);
  assign cur_valid = bus.s_tvalid[grant_ch];
  assign last_beat = (beat_cnt == len_q);
  assign xfer      = streaming && cur_valid && bus.m_tready;
  assign busy      = streaming;

  // m_tvalid never looks at m_tready; only the upstream ready follows it.
  always_comb begin
    bus.s_tready = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tdata  = '0;
    bus.m_tuser  = '0;
    bus.m_tlast  = 1'b0;
    if (streaming) begin
      bus.s_tready[grant_ch] = bus.m_tready;
      bus.m_tvalid           = cur_valid;
      bus.m_tdata            = bus.s_tdata[grant_ch*DATA_W +: DATA_W];
      bus.m_tuser            = USER_W'(grant_ch);
      bus.m_tlast            = cur_valid && last_beat;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      rr_ptr   <= CH_W'(N_CH - 1);
      grant_ch <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) state <= ARB;
        end
        ARB: begin
          if (!enable) begin
            state <= IDLE;
          end else if (arb_any) begin
            grant_ch <= arb_idx;
            rr_ptr   <= arb_idx;
            len_q    <= pkt_len;
            beat_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          // Grant is held across valid gaps and ready stalls until the last beat moves.
          if (xfer) begin
            if (last_beat) begin
              beat_cnt <= '0;
              pkt_done <= 1'b1;
              state    <= ARB;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/packet_stream_arbiter.md
Name: packet_stream_arbiter

Overview:
- Shares one downstream AXI-Stream packet path between N_CH upstream ADC sample streams.
- Grants one channel at a time for a whole packet of (pkt_len+1) beats and asserts m_tlast on the final beat.
- Uses round-robin selection between packets and tags every beat with the granted channel index in m_tuser.
- Sits between the per-channel sample FIFOs and the DMA/packet formatter.

Parameters:
- N_CH, 4, number of upstream channels (2..16).
- DATA_W, 32, sample width.
- USER_W, 8, output tuser width; must be >= CH_W.
- LEN_W, 8, packet length field width; packet length is 1..2^LEN_W beats.
- CH_W, $clog2(N_CH), derived channel index width; not overridable.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, arbitration enable; sampled only in IDLE/ARB.
- pkt_len, in, LEN_W, beats per packet minus 1; latched at grant.
- s_tdata, in, N_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- s_tvalid, in, N_CH, per-channel valid.
- s_tready, out, N_CH, per-channel ready.
- m_tdata, out, DATA_W, granted channel data.
- m_tuser, out, USER_W, granted channel index, zero-extended.
- m_tvalid, out, 1, output valid.
- m_tready, in, 1, downstream ready.
- m_tlast, out, 1, final beat of the packet.
- grant_ch, out, CH_W, current or last granted channel.
- busy, out, 1, high in STREAM.
- pkt_done, out, 1, one-cycle pulse after each packet's last beat is accepted.

Behaviour:
- Reset values:
  - state=IDLE, beat_cnt=0, len_q=0, rr_ptr=N_CH-1 (so channel 0 wins first).
  - grant_ch=0, busy=0, pkt_done=0.
  - All s_tready=0; m_tvalid=0, m_tlast=0; m_tdata/m_tuser are 0 when not in STREAM.
- State IDLE:
  - Outputs idle.
  - enable=1 -> ARB next cycle.
- State ARB (one cycle, one bubble per packet):
  - enable=0 -> IDLE.
  - No s_tvalid set -> stay in ARB.
  - Otherwise grant the first channel with s_tvalid=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_CH.
  - On grant, latch gnt=grant_ch, len_q=pkt_len, clear beat_cnt, set rr_ptr=gnt, then go to STREAM.
- State STREAM, combinational passthrough with zero added latency:
  - m_tvalid = s_tvalid[gnt].
  - m_tdata = s_tdata of gnt.
  - m_tuser = gnt.
  - s_tready[gnt] = m_tready; all other s_tready = 0.
  - m_tlast = m_tvalid && (beat_cnt == len_q).
- Beat accounting:
  - A beat transfers when s_tvalid[gnt] && m_tready.
  - On a non-final transfer, beat_cnt increments by 1 (LEN_W bits, never wraps past len_q).
  - On the final transfer (beat_cnt == len_q), go to ARB, clear beat_cnt, and pulse pkt_done on the next cycle.
- Packet integrity:
  - A packet is never truncated or interleaved.
  - The grant holds through s_tvalid gaps and m_tready stalls, however long.
- enable deasserted during STREAM: the current packet completes, then ARB sees enable=0 and returns to IDLE.
- pkt_len changes mid-packet: no effect until the next grant.
- pkt_len=0: single-beat packets; m_tlast is set on every beat.
- pkt_len=all-ones: 2^LEN_W beats.
- Simultaneous requests: resolved only by round-robin order, with no priority. Throughput per channel is fair at packet granularity.
- Reset mid-packet: immediate return to reset values; the partial packet is abandoned without m_tlast.
- m_tvalid must not depend on m_tready (AXI rule); s_tready may depend on m_tready.

Decomposition:
- Shared package pkt_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARB, STREAM} arb_state_t.
  - Default constants for N_CH, LEN_W, DATA_W.
- One natural sub-module, rr_arbiter: combinational round-robin priority pick.
  - Inputs: req[N_CH], ptr[CH_W].
  - Outputs: gnt_idx[CH_W], gnt_any.
  - Verified standalone.
- The top level holds the FSM, counters and the output mux.

Test Plan:
- Reset, enable=1, pkt_len=3, only ch2 valid with data 0x200..0x207, m_tready=1:
  - Two packets of 4 beats each.
  - m_tuser=2 throughout.
  - m_tlast on 0x203 and 0x207.
  - One idle bubble between packets.
  - pkt_done pulses twice.
- All 4 channels continuously valid, pkt_len=1:
  - Grant order is 0,1,2,3,0.
  - Each packet is exactly 2 beats.
  - No interleaving of channels within a packet.
- Backpressure: toggle m_tready randomly and insert 3-cycle s_tvalid gaps on the granted channel, pkt_len=7:
  - Exactly 8 transfers per packet.
  - Data order is preserved.
  - Non-granted s_tready stays 0 throughout.
- pkt_len=0 with ch1 and ch3 valid:
  - Alternating single-beat packets 1,3,1,3.
  - m_tlast=1 on every beat.
- Drop enable at beat 2 of an 8-beat packet:
  - Packet completes all 8 beats with m_tlast.
  - FSM enters IDLE; no new grant while enable=0.
  - Change pkt_len mid-packet and confirm the new value applies only to the next packet.
- Assert rst at beat 5 of a 256-beat packet (pkt_len=255):
  - Next cycle all outputs are at reset values and m_tlast was never asserted.
  - After release, ch0 receives the first grant and the packet is a full 256 beats.
